// File: rtl/axil_adder_array.sv
// AXI4-Lite slave with NUM_CH adder channels (OPA, OPB, registered SUM, STATUS).
// Optional build macro ADDER_SATURATE_EN selects a signed saturating SUM.
module axil_adder_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both
  // high; once valid is raised it holds until that edge, and B/R payloads stay
  // stable while bvalid/rvalid wait for bready/rready.

  localparam int SW   = DATA_WIDTH / 8;
  localparam int MSB  = DATA_WIDTH - 1;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(NUM_CH * 16);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef ADDER_SATURATE_EN
  localparam logic SAT_FLAG = 1'b1;
`else
  localparam logic SAT_FLAG = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t w_state_q, w_state_d;
  rstate_t r_state_q, r_state_d;
  logic                  ready_en_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [SW-1:0]         w_strb_q, w_strb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [DATA_WIDTH-1:0] opa_q [NUM_CH];
  logic [DATA_WIDTH-1:0] opb_q [NUM_CH];
  logic [DATA_WIDTH-1:0] sum_q [NUM_CH];
  logic                  carry_q [NUM_CH];
  logic                  ovf_q   [NUM_CH];
  logic                  valid_q [NUM_CH];

  logic aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [SW-1:0]         cm_strb;
  logic [CH_W-1:0]       cm_ch;
  logic [1:0]            cm_reg;
  logic                  cm_ok, cm_apply;

  logic [DATA_WIDTH-1:0] opa_d, opb_d, sum_d;
  logic [DATA_WIDTH:0]   add_full;
  logic                  carry_d, ovf_d;

  logic [CH_W-1:0]       ar_ch;
  logic [1:0]            ar_reg;
  logic                  ar_ok;
  logic [DATA_WIDTH-1:0] rd_word;

  // Readys stay low until one clock after reset is released.
  assign s1_axi_awready = ready_en_q && (w_state_q == W_IDLE || w_state_q == W_DATA);
  assign s1_axi_wready  = ready_en_q && (w_state_q == W_IDLE || w_state_q == W_ADDR);
  assign s1_axi_bvalid  = (w_state_q == W_RESP);
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_arready = ready_en_q && (r_state_q == R_IDLE);
  assign s1_axi_rvalid  = (r_state_q == R_DATA);
  assign s1_axi_rdata   = rdata_q;
  assign s1_axi_rresp   = rresp_q;

  assign aw_hs = s1_axi_awvalid && s1_axi_awready;
  assign w_hs  = s1_axi_wvalid && s1_axi_wready;
  assign ar_hs = s1_axi_arvalid && s1_axi_arready;

  // The half that arrived first is taken from the holding register.
  assign cm_addr  = (w_state_q == W_ADDR) ? aw_addr_q : s1_axi_awaddr;
  assign cm_data  = (w_state_q == W_DATA) ? w_data_q : s1_axi_wdata;
  assign cm_strb  = (w_state_q == W_DATA) ? w_strb_q : s1_axi_wstrb;
  assign cm_ch    = CH_W'(cm_addr >> 4);
  assign cm_reg   = cm_addr[3:2];
  assign cm_ok    = ({1'b0, cm_addr} < ADDR_LIMIT) && !cm_reg[1];
  assign cm_apply = commit && cm_ok && (|cm_strb);

  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          aw_addr_d = s1_axi_awaddr;
          w_state_d = W_ADDR;
        end else if (w_hs) begin
          w_data_d  = s1_axi_wdata;
          w_strb_d  = s1_axi_wstrb;
          w_state_d = W_DATA;
        end
      end
      W_ADDR: if (w_hs) commit = 1'b1;
      W_DATA: if (aw_hs) commit = 1'b1;
      W_RESP: if (s1_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    if (commit) begin
      bresp_d   = cm_ok ? RESP_OKAY : RESP_SLVERR;
      w_state_d = W_RESP;
    end
  end

  // New operands are merged here so SUM is computed from them in the commit cycle.
  always_comb begin
    opa_d = opa_q[cm_ch];
    opb_d = opb_q[cm_ch];
    for (int b = 0; b < SW; b++) begin
      if (cm_strb[b]) begin
        if (!cm_reg[0]) opa_d[8*b +: 8] = cm_data[8*b +: 8];
        else            opb_d[8*b +: 8] = cm_data[8*b +: 8];
      end
    end
    add_full = {1'b0, opa_d} + {1'b0, opb_d};
    carry_d  = add_full[DATA_WIDTH];
    ovf_d    = (opa_d[MSB] == opb_d[MSB]) && (add_full[MSB] != opa_d[MSB]);
    sum_d    = add_full[DATA_WIDTH-1:0];
`ifdef ADDER_SATURATE_EN
    if (ovf_d) sum_d = opa_d[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
`endif
  end

  assign ar_ch  = CH_W'(s1_axi_araddr >> 4);
  assign ar_reg = s1_axi_araddr[3:2];
  assign ar_ok  = ({1'b0, s1_axi_araddr} < ADDR_LIMIT);

  always_comb begin
    rd_word = '0;
    if (ar_ok) begin
      unique case (ar_reg)
        2'd0: rd_word = opa_q[ar_ch];
        2'd1: rd_word = opb_q[ar_ch];
        2'd2: rd_word = sum_q[ar_ch];
        default: rd_word = {{(DATA_WIDTH-4){1'b0}}, SAT_FLAG,
                            valid_q[ar_ch], ovf_q[ar_ch], carry_q[ar_ch]};
      endcase
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d   = rd_word;
          rresp_d   = ar_ok ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: if (s1_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      ready_en_q <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int c = 0; c < NUM_CH; c++) begin
        opa_q[c]   <= '0;
        opb_q[c]   <= '0;
        sum_q[c]   <= '0;
        carry_q[c] <= 1'b0;
        ovf_q[c]   <= 1'b0;
        valid_q[c] <= 1'b0;
      end
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      ready_en_q <= 1'b1;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      if (cm_apply) begin
        opa_q[cm_ch]   <= opa_d;
        opb_q[cm_ch]   <= opb_d;
        sum_q[cm_ch]   <= sum_d;
        carry_q[cm_ch] <= carry_d;
        ovf_q[cm_ch]   <= ovf_d;
        valid_q[cm_ch] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axil_adder_array.sv
// Directed and randomized bench for axil_adder_array (default parameters),
// checked against an arithmetic register-map model.
module tb_axil_adder_array;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int NCH = 4;
  localparam int SW  = DW / 8;
`ifdef ADDER_SATURATE_EN
  localparam logic [31:0] SAT_BIT = 32'h8;
`else
  localparam logic [31:0] SAT_BIT = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  axil_adder_array dut (
    .s1_axi_aclk(clk), .s1_axi_areset(rst),
    .s1_axi_awaddr(awaddr), .s1_axi_awvalid(awvalid), .s1_axi_awready(awready),
    .s1_axi_wdata(wdata), .s1_axi_wstrb(wstrb), .s1_axi_wvalid(wvalid), .s1_axi_wready(wready),
    .s1_axi_bresp(bresp), .s1_axi_bvalid(bvalid), .s1_axi_bready(bready),
    .s1_axi_araddr(araddr), .s1_axi_arvalid(arvalid), .s1_axi_arready(arready),
    .s1_axi_rdata(rdata), .s1_axi_rresp(rresp), .s1_axi_rvalid(rvalid), .s1_axi_rready(rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_opa [NCH];
  logic [31:0] m_opb [NCH];
  logic        m_valid [NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic longint m_ssum(int c);
    return longint'($signed(m_opa[c])) + longint'($signed(m_opb[c]));
  endfunction

  function automatic logic m_ovf(int c);
    longint s = m_ssum(c);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic logic [31:0] m_sum(int c);
    longint s = m_ssum(c);
`ifdef ADDER_SATURATE_EN
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return m_opa[c] + m_opb[c];
  endfunction

  function automatic logic [31:0] m_status(int c);
    longint unsigned u = longint'(m_opa[c]) + longint'(m_opb[c]);
    logic carry = (u > 64'hFFFF_FFFF);
    if (!m_valid[c]) return SAT_BIT;
    return SAT_BIT | 32'h4 | (m_ovf(c) ? 32'h2 : 32'h0) | (carry ? 32'h1 : 32'h0);
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_opa[c] = 0; m_opb[c] = 0; m_valid[c] = 0;
    end
  endtask

  task automatic m_read(input int addr, output logic [31:0] d, output logic [1:0] r);
    int c = addr / 16;
    int k = (addr % 16) / 4;
    d = 0; r = 2'b10;
    if (addr < NCH * 16) begin
      r = 2'b00;
      case (k)
        0: d = m_opa[c];
        1: d = m_opb[c];
        2: d = m_valid[c] ? m_sum(c) : 32'h0;
        default: d = m_status(c);
      endcase
    end
  endtask

  task automatic m_write(input int addr, input logic [31:0] d, input logic [3:0] s,
                         output logic [1:0] r);
    int c = addr / 16;
    int k = (addr % 16) / 4;
    if (addr >= NCH * 16 || k >= 2) begin
      r = 2'b10;
    end else begin
      r = 2'b00;
      if (s != 0) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) begin
            if (k == 0) m_opa[c][8*b +: 8] = d[8*b +: 8];
            else        m_opb[c][8*b +: 8] = d[8*b +: 8];
          end
        end
        m_valid[c] = 1;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic run_hs();
    int budget = 50;
    while (awvalid || wvalid) begin
      logic at, wt;
      at = awvalid && awready;
      wt = wvalid && wready;
      tick();
      if (at) awvalid = 0;
      if (wt) wvalid = 0;
      budget--;
      if (budget == 0 && (awvalid || wvalid)) begin
        check("aw_w_timeout", 32'd0, 32'd1);
        awvalid = 0; wvalid = 0;
      end
    end
  endtask

  // mode 0: AW+W together, 1: AW first, 2: W first; gap idle cycles between halves.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int mode, input int gap, output logic [1:0] resp);
    int budget = 50;
    awaddr = a; wdata = d; wstrb = s;
    if (mode == 0) begin
      awvalid = 1; wvalid = 1; run_hs();
    end else if (mode == 1) begin
      awvalid = 1; run_hs();
      check("w_addr_readys", {30'd0, awready, wready}, 32'h1);
      repeat (gap) tick();
      wvalid = 1; run_hs();
    end else begin
      wvalid = 1; run_hs();
      check("w_data_readys", {30'd0, awready, wready}, 32'h2);
      repeat (gap) tick();
      awvalid = 1; run_hs();
    end
    bready = 1;
    while (!bvalid && budget > 0) begin tick(); budget--; end
    check("b_seen", {31'd0, bvalid}, 32'h1);
    resp = bresp;
    tick();
    bready = 0;
    check("b_single", {31'd0, bvalid}, 32'h0);
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int budget = 50;
    araddr = a; arvalid = 1;
    while (!arready && budget > 0) begin tick(); budget--; end
    tick();
    arvalid = 0;
    check("r_latency", {31'd0, rvalid}, 32'h1);
    d = rdata; r = rresp;
    rready = 1;
    tick();
    rready = 0;
  endtask

  task automatic wr_check(input string tag, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int mode, input int gap);
    logic [1:0] got, exp;
    axi_write(a, d, s, mode, gap, got);
    m_write(a, d, s, exp);
    check(tag, {30'd0, got}, {30'd0, exp});
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a);
    logic [31:0] gd, ed;
    logic [1:0]  gr, er;
    axi_read(a, gd, gr);
    m_read(a, ed, er);
    check(tag, gd, ed);
    check({tag, "_resp"}, {30'd0, gr}, {30'd0, er});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    m_reset();
    repeat (3) tick();
    check("rst_readys", {29'd0, awready, wready, arready}, 32'h0);
    check("rst_valids", {30'd0, bvalid, rvalid}, 32'h0);
    check("rst_resps", {28'd0, bresp, rresp}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 0;
    check("ready_pre", {29'd0, awready, wready, arready}, 32'h0);
    tick();
    check("ready_post", {29'd0, awready, wready, arready}, 32'h7);
    rd_check("status_rst", 8'h0C);

    wr_check("w_opa0", 8'h00, 32'd39, 4'hF, 0, 0);
    wr_check("w_opb0", 8'h04, 32'd40, 4'hF, 0, 0);
    axi_read(8'h08, d, r);
    check("sum79", d, 32'd79);
    rd_check("status0", 8'h0C);

    wr_check("w_opa2_wfirst", 8'h20, 32'hFFFFFFFF, 4'hF, 2, 3);
    wr_check("w_opb2", 8'h24, 32'd1, 4'hF, 1, 2);
    rd_check("sum2", 8'h28);
    axi_read(8'h2C, d, r);
    check("status2", d, 32'h5 | SAT_BIT);
    rd_check("opa0_kept", 8'h00);

    wr_check("w_opa1", 8'h10, 32'h7FFFFFFF, 4'hF, 0, 0);
    wr_check("w_opb1", 8'h14, 32'd1, 4'hF, 0, 0);
    axi_read(8'h18, d, r);
`ifdef ADDER_SATURATE_EN
    check("sum1_sat", d, 32'h7FFFFFFF);
`else
    check("sum1_wrap", d, 32'h80000000);
`endif
    rd_check("status1", 8'h1C);

    wr_check("w_sum_ro", 8'h08, 32'h1234, 4'hF, 0, 0);
    wr_check("w_oor", 8'h40, 32'h1234, 4'hF, 0, 0);
    rd_check("r_oor", 8'h40);
    rd_check("sum0_kept", 8'h08);
    wr_check("w_full", 8'h00, 32'h11223344, 4'hF, 0, 0);
    wr_check("w_part", 8'h00, 32'h000000AB, 4'h1, 0, 0);
    axi_read(8'h00, d, r);
    check("opa_partial", d, 32'h112233AB);
    wr_check("w_strb0", 8'h04, 32'hDEADBEEF, 4'h0, 0, 0);
    rd_check("opb_strb0", 8'h04);

    // Same-cycle read and write of OPA: read returns the old value.
    m_read(8'h00, ed, er);
    awaddr = 8'h00; araddr = 8'h00; wdata = 32'hCAFE0001; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("rw_same_old", rdata, ed);
    m_write(8'h00, 32'hCAFE0001, 4'hF, er);
    check("rw_same_bresp", {30'd0, bresp}, {30'd0, er});
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;

    // SUM read accepted in the bvalid cycle sees the new sum.
    awaddr = 8'h04; wdata = 32'h00000100; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    m_write(8'h04, 32'h00000100, 4'hF, er);
    araddr = 8'h08; arvalid = 1; bready = 1;
    tick();
    arvalid = 0; bready = 0;
    check("sum_at_bvalid", rdata, m_sum(0));
    rready = 1; tick(); rready = 0;

    // Backpressure on B and R.
    awaddr = 8'h08; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1; run_hs();
    m_write(8'h08, 32'h5, 4'hF, er);
    for (int i = 0; i < 5; i++) begin
      check("b_hold", {28'd0, bvalid, awready, wready, 1'b0}, 32'h8);
      check("b_hold_resp", {30'd0, bresp}, {30'd0, er});
      tick();
    end
    bready = 1; tick(); bready = 0;
    m_read(8'h08, ed, er);
    araddr = 8'h08; arvalid = 1; tick(); arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check("r_hold", {30'd0, rvalid, arready}, 32'h2);
      check("r_hold_data", rdata, ed);
      tick();
    end
    rready = 1; tick(); rready = 0;

    // Reset while the write FSM waits for W.
    awaddr = 8'h00; awvalid = 1; run_hs();
    check("mid_w_addr", {30'd0, awready, wready}, 32'h1);
    rst = 1; tick(); rst = 0;
    m_reset();
    check("rst_mid_bvalid", {31'd0, bvalid}, 32'h0);
    tick();
    check("rst_mid_readys", {29'd0, awready, wready, bvalid}, 32'h6);
    rd_check("opa_after_rst", 8'h00);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 8'h4F));
      if ($urandom_range(0, 2) != 0)
        wr_check("rnd_w", a, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      else
        rd_check("rnd_r", a);
    end
    for (int a = 0; a < NCH * 16; a += 4) rd_check("sweep", 8'(a));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
